// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchroniser, glitch filter, frame FSM and first-word-fall-through scancode FIFO.
// Define PS2_RX_PREFIX_DECODE_EN to fold 0xE0/0xF0 prefixes into is_ext/is_brk flags.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 19,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_brk,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_RX_PREFIX_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input conditioning: bit 0 is the clock line, bit 1 the data line
  logic [1:0]      sync1, sync2, filt;
  logic [1:0][7:0] fcnt;
  logic            filt_clk_d;
  logic            fall_p0;
  logic            smp_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      fcnt       <= '0;
      filt_clk_d <= 1'b1;
      fall_p0    <= 1'b0;
    end else begin
      sync1      <= {ps2_data, ps2_clk};
      sync2      <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 8'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
      filt_clk_d <= filt[0];
      fall_p0    <= filt_clk_d & ~filt[0];
    end
  end

  assign smp_p0 = filt[1];

  // Frame FSM: consumes fall_p0/smp_p0, produces accepted byte in stage p1
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_d, acc_d;
  logic          acc_vld_p1;
  logic [7:0]    acc_byte_p1;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tmo_d   = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
    err_d   = 1'b0;
    acc_d   = 1'b0;
    if (fall_p0) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!smp_p0) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          sh_d   = {smp_p0, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = smp_p0;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (smp_p0 && (^{sh_q, par_q})) acc_d = 1'b1;
          else err_d = 1'b1;
        end
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      frame_err  <= 1'b0;
      acc_vld_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      frame_err  <= err_d;
      acc_vld_p1 <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q        <= sh_d;
    acc_byte_p1 <= sh_q;
  end

  // Stage p2: prefix folding and FIFO write
  logic          push_en;
  logic [EW-1:0] push_word;

`ifdef PS2_RX_PREFIX_DECODE_EN
  logic pend_ext, pend_brk;
  logic is_prefix;

  assign is_prefix = (acc_byte_p1 == 8'hE0) || (acc_byte_p1 == 8'hF0);
  assign push_en   = acc_vld_p1 && !is_prefix;
  assign push_word = {pend_ext, pend_brk, acc_byte_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (frame_err) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (acc_vld_p1) begin
      if (acc_byte_p1 == 8'hE0) begin
        pend_ext <= 1'b1;
      end else if (acc_byte_p1 == 8'hF0) begin
        pend_brk <= 1'b1;
      end else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end
`else
  assign push_en   = acc_vld_p1;
  assign push_word = acc_byte_p1;
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, do_push;
  logic [EW-1:0] head;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid && ready;
  assign do_push = push_en && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      overflow <= push_en && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // Head is gated so outputs read 0 whenever the FIFO is empty, including in reset
  assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign code = head[7:0];
`ifdef PS2_RX_PREFIX_DECODE_EN
  assign is_ext = head[9];
  assign is_brk = head[8];
`else
  assign is_ext = 1'b0;
  assign is_brk = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, prefixes, parity/timeout errors, overflow, reset, glitches.
module tb_ps2_rx_fifo;
  localparam int FL = 19;
  localparam int TO = 2000;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] code;
  logic       is_ext, is_brk, valid, frame_err, overflow;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int f0, o0;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .is_ext(is_ext), .is_brk(is_brk), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "cycle budget exhausted");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: check push latency after stop fall, 2: pop on the push cycle
  task automatic send(input logic [7:0] b, input bit flip, input int nbits,
                      input int mode, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        cyc(5); ps2_clk = 1'b0; cyc(5); ps2_clk = 1'b1; cyc(10);
      end else begin
        cyc(20);
      end
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        cyc(23);
        chk("lat_pre_valid", valid, 0);
        cyc(1);
        chk("lat_valid", valid, 1);
        chk("lat_code", code, b);
        cyc(16);
      end else if (i == 10 && mode == 2) begin
        cyc(23); ready = 1'b1; cyc(1); ready = 1'b0; cyc(16);
      end else begin
        cyc(40);
      end
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic pop(input string tag, input logic [7:0] c, input logic e, input logic k);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_code"}, code, c);
    chk({tag, "_ext"}, is_ext, e);
    chk({tag, "_brk"}, is_brk, k);
    ready = 1'b1; cyc(1); ready = 1'b0; cyc(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_code"}, code, 0);
    chk({tag, "_ext"}, is_ext, 0);
    chk({tag, "_brk"}, is_brk, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    chk_all_zero("rst");
    rst_n = 1'b1;
    cyc(5);

    // Plain frame with latency check
    send(8'h1C, 0, 11, 1, 0);
    chk("t1_ferr", ferr_cnt, 0);
    pop("t1", 8'h1C, 0, 0);
    chk("t1_empty", valid, 0);

    // Prefix bytes
`ifdef PS2_RX_PREFIX_DECODE_EN
    send(8'hE0, 0, 11, 0, 0);
    chk("t2_e0_none", valid, 0);
    send(8'hF0, 0, 11, 0, 0);
    chk("t2_f0_none", valid, 0);
    send(8'h74, 0, 11, 0, 0);
    pop("t2_74", 8'h74, 1, 1);
    chk("t2_single", valid, 0);
`else
    send(8'hE0, 0, 11, 0, 0);
    send(8'hF0, 0, 11, 0, 0);
    send(8'h74, 0, 11, 0, 0);
    pop("t2_e0", 8'hE0, 0, 0);
    pop("t2_f0", 8'hF0, 0, 0);
    pop("t2_74", 8'h74, 0, 0);
`endif
    send(8'h1C, 0, 11, 0, 0);
    pop("t2_plain", 8'h1C, 0, 0);

    // Parity error then good frame
    f0 = ferr_cnt;
    send(8'h1C, 1, 11, 0, 0);
    chk("t3_ferr", ferr_cnt - f0, 1);
    chk("t3_noentry", valid, 0);
    send(8'h1B, 0, 11, 0, 0);
    pop("t3_1b", 8'h1B, 0, 0);
    chk("t3_ferr_after", ferr_cnt - f0, 1);

    // Timeout after 5 bits
    f0 = ferr_cnt;
    send(8'h55, 0, 5, 0, 0);
    cyc(TO + 10);
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_noentry", valid, 0);
    send(8'h29, 0, 11, 0, 0);
    pop("t4_29", 8'h29, 0, 0);
    chk("t4_ferr_after", ferr_cnt - f0, 1);

    // Overflow and push-with-pop on full
    o0 = ovf_cnt;
    for (int i = 0; i < FD; i++) send(8'(8'h11 * (i + 1)), 0, 11, 0, 0);
    chk("t5_ovf_none", ovf_cnt - o0, 0);
    send(8'h55, 0, 11, 0, 0);
    chk("t5_ovf_one", ovf_cnt - o0, 1);
    chk("t5_head", code, 8'h11);
    send(8'h66, 0, 11, 2, 0);
    chk("t5_ovf_pop", ovf_cnt - o0, 1);
    pop("t5_22", 8'h22, 0, 0);
    pop("t5_33", 8'h33, 0, 0);
    pop("t5_44", 8'h44, 0, 0);
    pop("t5_66", 8'h66, 0, 0);
    chk("t5_empty", valid, 0);

    // Reset mid-frame with an entry pending
    send(8'h2A, 0, 11, 0, 0);
    chk("t6_pre_valid", valid, 1);
    send(8'h47, 0, 4, 0, 0);
    rst_n = 1'b0;
    #2;
    chk_all_zero("t6_rst");
    cyc(2);
    chk_all_zero("t6_rst_hold");
    rst_n = 1'b1;
    cyc(5);
    f0 = ferr_cnt;
    send(8'h3C, 0, 11, 0, 0);
    pop("t6_3c", 8'h3C, 0, 0);
    chk("t6_empty", valid, 0);
    chk("t6_ferr", ferr_cnt - f0, 0);

    // Short glitches on the clock line
    f0 = ferr_cnt;
    repeat (3) begin
      ps2_clk = 1'b0; cyc(5); ps2_clk = 1'b1; cyc(30);
    end
    chk("t7_idle_ferr", ferr_cnt - f0, 0);
    chk("t7_idle_valid", valid, 0);
    send(8'h5A, 0, 11, 0, 1);
    pop("t7_5a", 8'h5A, 0, 0);
    chk("t7_empty", valid, 0);
    chk("t7_ferr", ferr_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
